packet_gen: RTL and testbench

//   Source stage for the cable test: emits fixed-length pseudo-random packets on AXIS_OUT (to the cable TX path)
//   and, beat-for-beat, an identical copy on AXIS_FIFO_OUT (into the expected-data FIFO feeding the receiver).
//   The receiver compares cable data against the FIFO copy, so both streams must carry exactly the same beats in
//   the same order. A run is N packets of L beats; software starts/stops it via control inputs.

---
 rtl/packet_gen_pkg.sv | 23 ++
 rtl/packet_gen_if.sv | 20 ++
 rtl/packet_gen_lfsr32.sv | 25 ++
 rtl/packet_gen.sv | 117 +++++++++++
 tb/tb_packet_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_gen_pkg.sv
// Shared constants, state encoding and LFSR step for the cable-test packet source.
package packet_gen_pkg;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2345;
    localparam int          LANE_TAG_W   = 8;
    localparam int          LANE_DATA_W  = 32 - LANE_TAG_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Galois right-shift form: feed back the bit shifted out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ LFSR_TAPS;
        return r;
    endfunction

endpackage

// File: rtl/packet_gen_if.sv
// AXI4-Stream bundle used for both the cable and expected-data outputs.
interface packet_gen_if #(
    parameter int DATA_W = 512
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/packet_gen_lfsr32.sv
// 32-bit Galois LFSR; reload on start, one step per completed beat.
module lfsr32
    import packet_gen_pkg::*;
#(
    parameter logic [31:0] SEED  = DEFAULT_SEED,
    parameter int          OUT_W = LANE_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [OUT_W-1:0] value
);
    logic [31:0] r_value;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_value <= SEED;
        end else if (advance) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign value = r_value[OUT_W-1:0];
endmodule

// File: rtl/packet_gen.sv
// Pseudo-random packet source driving the cable and its expected-data FIFO in lockstep.
module packet_gen
    import packet_gen_pkg::*;
#(
    parameter int          DATA_W = 512,
    parameter int          LEN_W  = 16,
    parameter logic [31:0] SEED   = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] packet_len,
    input  logic [31:0]      packet_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      packets_sent,
    packet_gen_if.master     axis_out,
    packet_gen_if.master     axis_fifo_out
);
    localparam int LANES = DATA_W / 32;

    state_t           r_state, w_next;
    logic [LEN_W-1:0] r_len, r_beat;
    logic [31:0]      r_count, r_sent;
    logic             r_taken_c, r_taken_f, r_stop_pend;

    logic w_valid_c, w_valid_f, w_got_c, w_got_f;
    logic w_beat_done, w_last, w_start, w_end;
    logic [LANE_DATA_W-1:0] w_lfsr;
    logic [DATA_W-1:0]      w_data;

    assign w_start   = (r_state == IDLE) && start;
    assign w_valid_c = (r_state == RUN) && !r_taken_c;
    assign w_valid_f = (r_state == RUN) && !r_taken_f;
    assign w_got_c   = r_taken_c || (w_valid_c && axis_out.tready);
    assign w_got_f   = r_taken_f || (w_valid_f && axis_fifo_out.tready);

    // A beat retires only once both streams hold it.
    assign w_beat_done = (r_state == RUN) && w_got_c && w_got_f;
    assign w_last      = (r_beat == r_len - {{(LEN_W-1){1'b0}}, 1'b1});
    assign w_end       = w_beat_done && w_last &&
                         ((r_sent + 32'd1 == r_count) || r_stop_pend || stop);

    lfsr32 #(.SEED(SEED), .OUT_W(LANE_DATA_W)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (w_start),
        .advance (w_beat_done),
        .value   (w_lfsr)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = (packet_count == 32'd0) ? DONE : RUN;
            RUN:     if (w_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_len       <= {{(LEN_W-1){1'b0}}, 1'b1};
            r_count     <= '0;
            r_sent      <= '0;
            r_beat      <= '0;
            r_taken_c   <= 1'b0;
            r_taken_f   <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_len       <= (packet_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : packet_len;
                r_count     <= packet_count;
                r_sent      <= '0;
                r_beat      <= '0;
                r_taken_c   <= 1'b0;
                r_taken_f   <= 1'b0;
                r_stop_pend <= 1'b0;
            end else if (r_state == RUN) begin
                if (stop) r_stop_pend <= 1'b1;
                if (w_beat_done) begin
                    r_taken_c <= 1'b0;
                    r_taken_f <= 1'b0;
                    r_beat    <= w_last ? '0 : r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
                    if (w_last) r_sent <= r_sent + 32'd1;
                end else begin
                    r_taken_c <= w_got_c;
                    r_taken_f <= w_got_f;
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < LANES; i++) begin
            w_data[i*32 +: 32] = {LANE_TAG_W'(i), w_lfsr};
        end
    end

    assign axis_out.tdata       = w_data;
    assign axis_out.tkeep       = '1;
    assign axis_out.tlast       = w_last;
    assign axis_out.tvalid      = w_valid_c;
    assign axis_fifo_out.tdata  = w_data;
    assign axis_fifo_out.tkeep  = '1;
    assign axis_fifo_out.tlast  = w_last;
    assign axis_fifo_out.tvalid = w_valid_f;

    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign packets_sent = r_sent;
endmodule

// File: tb/tb_packet_gen.sv
// Table-driven scoreboard bench for packet_gen: both streams checked beat by beat.
module tb_packet_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] len = '0;
    logic [31:0] cnt = '0;
    logic        busy, done;
    logic [31:0] sent;

    packet_gen_if #(.DATA_W(512)) ax_c ();
    packet_gen_if #(.DATA_W(512)) ax_f ();

    packet_gen dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .packet_len    (len),
        .packet_count  (cnt),
        .busy          (busy),
        .done          (done),
        .packets_sent  (sent),
        .axis_out      (ax_c),
        .axis_fifo_out (ax_f)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        int len;
        int cnt;
        int mode;
        int stop_at;
        int exp_beats;
        int exp_sent;
    } vec_t;

    beat_t qc[$];
    beat_t qf[$];
    vec_t  tbl[6];

    int checks = 0;
    int failures = 0;
    int nc = 0, nf = 0, ndone = 0;
    int nf_base = 0;
    int mode = 0;
    int stall = 0;
    logic [31:0]  sent_at_done = '0;
    logic         hold_c = 1'b0, hold_f = 1'b0;
    logic [511:0] hold_dc, hold_df;
    beat_t        mb;

    task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    function automatic logic [31:0] m_next(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic push_exp(input int leff, input int n);
        logic [31:0] s;
        beat_t b;
        s = 32'hACE1_2345;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 16; i++) b.d[i*32 +: 32] = {i[7:0], s[23:0]};
            b.l = ((k % leff) == leff - 1);
            qc.push_back(b);
            qf.push_back(b);
            s = m_next(s);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mode == 1) begin
            ax_c.tready = 1'($urandom_range(0, 1));
            ax_f.tready = 1'($urandom_range(0, 1));
        end else if (mode == 2 && nf - nf_base == 1 && stall < 3) begin
            ax_c.tready = 1'b1;
            ax_f.tready = 1'b0;
            stall++;
        end else begin
            ax_c.tready = 1'b1;
            ax_f.tready = 1'b1;
            if (mode != 2) stall = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold_c = 1'b0;
            hold_f = 1'b0;
        end else begin
            if (hold_c) begin
                chk("cable_hold_valid", ax_c.tvalid, 1);
                chk("cable_hold_data", ax_c.tdata, hold_dc);
            end
            if (hold_f) begin
                chk("fifo_hold_valid", ax_f.tvalid, 1);
                chk("fifo_hold_data", ax_f.tdata, hold_df);
            end
            hold_c = ax_c.tvalid && !ax_c.tready;
            hold_f = ax_f.tvalid && !ax_f.tready;
            hold_dc = ax_c.tdata;
            hold_df = ax_f.tdata;
            if (ax_c.tvalid && ax_c.tready) begin
                if (qc.size() == 0) chk("cable_unexpected_beat", 1, 0);
                else begin
                    mb = qc.pop_front();
                    chk("cable_data", ax_c.tdata, mb.d);
                    chk("cable_last", ax_c.tlast, mb.l);
                    chk("cable_keep", ax_c.tkeep, {64{1'b1}});
                end
                nc++;
            end
            if (ax_f.tvalid && ax_f.tready) begin
                if (qf.size() == 0) chk("fifo_unexpected_beat", 1, 0);
                else begin
                    mb = qf.pop_front();
                    chk("fifo_data", ax_f.tdata, mb.d);
                    chk("fifo_last", ax_f.tlast, mb.l);
                    chk("fifo_keep", ax_f.tkeep, {64{1'b1}});
                end
                nf++;
            end
            chk("stream_skew", (nc - nf >= -1) && (nc - nf <= 1), 1);
            if (done) begin
                ndone++;
                sent_at_done = sent;
            end
        end
    end

    task automatic run_case(input vec_t c);
        int nc0, nf0, nd0;
        bit stopped;
        len = c.len[15:0];
        cnt = c.cnt;
        nc0 = nc;
        nf0 = nf;
        nd0 = ndone;
        nf_base = nf;
        stopped = 0;
        push_exp((c.len == 0) ? 1 : c.len, c.exp_beats);
        mode = c.mode;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("first_valid", ax_c.tvalid, (c.cnt != 0));
        chk("first_done", done, (c.cnt == 0));
        chk("busy_after_start", busy, 1);
        #1;
        for (int t = 0; t < 5000 && ndone == nd0; t++) begin
            @(posedge clk); #1;
            stop = (c.stop_at >= 0) && !stopped && (nc - nc0 >= c.stop_at);
            if (stop) stopped = 1;
            @(negedge clk); #1;
        end
        stop = 1'b0;
        chk("done_seen", ndone - nd0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("done_single", ndone - nd0, 1);
        chk("packets_sent", sent_at_done, c.exp_sent);
        chk("cable_beats", nc - nc0, c.exp_beats);
        chk("fifo_beats", nf - nf0, c.exp_beats);
        chk("cable_queue_left", qc.size(), 0);
        chk("fifo_queue_left", qf.size(), 0);
        chk("busy_idle", busy, 0);
        qc.delete();
        qf.delete();
        mode = 0;
    endtask

    initial begin
        vec_t v;
        int nc0, nd0;
        ax_c.tready = 1'b1;
        ax_f.tready = 1'b1;
        tbl[0] = '{len: 4, cnt: 3,   mode: 0, stop_at: -1, exp_beats: 12,  exp_sent: 3};
        tbl[1] = '{len: 2, cnt: 2,   mode: 2, stop_at: -1, exp_beats: 4,   exp_sent: 2};
        tbl[2] = '{len: 7, cnt: 20,  mode: 1, stop_at: -1, exp_beats: 140, exp_sent: 20};
        tbl[3] = '{len: 8, cnt: 100, mode: 0, stop_at: 13, exp_beats: 16,  exp_sent: 2};
        tbl[4] = '{len: 0, cnt: 1,   mode: 0, stop_at: -1, exp_beats: 1,   exp_sent: 1};
        tbl[5] = '{len: 3, cnt: 0,   mode: 0, stop_at: -1, exp_beats: 0,   exp_sent: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent, 0);
        chk("rst_cable_valid", ax_c.tvalid, 0);
        chk("rst_fifo_valid", ax_f.tvalid, 0);
        @(posedge clk); #1;
        stop = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        chk("idle_stop_ignored", busy, 0);

        for (int i = 0; i < 6; i++) run_case(tbl[i]);

        len = 16'd8;
        cnt = 32'd5;
        push_exp(8, 40);
        nc0 = nc;
        nd0 = ndone;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 200 && nc - nc0 < 5; t++) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cable_valid", ax_c.tvalid, 0);
        chk("abort_fifo_valid", ax_f.tvalid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", ndone - nd0, 0);
        chk("abort_still_idle", ax_c.tvalid, 0);
        qc.delete();
        qf.delete();
        v = '{len: 2, cnt: 1, mode: 0, stop_at: -1, exp_beats: 2, exp_sent: 1};
        run_case(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
